mbist_march_engine: RTL
=======================

Name: mbist_march_engine

Overview:
- Parametrised March C- MBIST engine with built-in repair-table capture for single-port SRAMs of any width and depth.
- Successor to the fixed 32-word MBIST controller; it also logs up to NUM_SPARES distinct failing addresses for MBISR remapping.
- Sits between the top-level control and the memory wrapper.
- Drives the memory port directly and exports done, fail and repair results.

Parameters:
- DATA_W, 8: memory word width (>=2).
- ADDR_W, 5: address width.
- DEPTH, 32: words tested, 2 <= DEPTH <= 2**ADDR_W.
- NUM_SPARES, 2: spare rows, i.e. repair table entries (1..8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request; honoured only in IDLE or DONE.
- busy  out  1  test in progress.
- done  out  1  test complete; held until restart or reset.
- fail  out  1  any mismatch seen.
- repair_ok  out  1  done & (fail_cnt <= NUM_SPARES).
- fail_cnt  out  $clog2(NUM_SPARES+2)  distinct failing addresses, saturating at NUM_SPARES+1.
- fail_addr  out  ADDR_W  first failing address.
- spare_addr  out  NUM_SPARES*ADDR_W  repair table; entry k at bits [k*ADDR_W +: ADDR_W].
- spare_vld  out  NUM_SPARES  entry valid bits.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable (qualified by mem_en).
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid the cycle after a read strobe.

Behaviour:
- One clock; reset is synchronous and active-high; ports are clk and rst.
- Reset values: all outputs 0; state IDLE; table cleared. Reset mid-test aborts immediately: mem_en=0 from the next cycle and no partial results are kept.
- States: IDLE, INIT, READ, CHECK, DONE. Element counter elem runs 0..5.
- March C- elements:
  - M0 ⇑w0
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇑r0
- Ascending sweeps run 0..DEPTH-1; descending sweeps run DEPTH-1..0. Addresses DEPTH..2**ADDR_W-1 are never touched.
- Data "0" = background BG; data "1" = ~BG. BG = 0 by default.
- start in IDLE or DONE:
  - clears done, fail, fail_cnt, fail_addr and the table;
  - sets busy;
  - enters INIT at address 0.
- start in any other state is ignored.
- INIT: one write of "0" per cycle (mem_en=1, mem_we=1). After DEPTH-1: elem=1, addr=0, go to READ.
- READ: issue the read (mem_en=1, mem_we=0), then go to CHECK.
- CHECK:
  - compare mem_rdata with the expected value for elem;
  - for elem 1..4, write the complement to the same address in the same cycle;
  - for elem 5, mem_en=0;
  - then step the address and go to READ.
  - At the sweep end: elem+1, address reloaded (DEPTH-1 for M3/M4, 0 otherwise).
  - After M5's last CHECK: go to DONE, clear busy, set done.
- Latency: done rises exactly 11*DEPTH+1 rising edges after the edge that samples start.
- Mismatch handling:
  - fail=1.
  - On the first mismatch, fail_addr=address.
  - If the address matches a valid entry: no change.
  - Else, if a free entry exists: write it at the lowest free index, set its vld, increment fail_cnt.
  - Else: fail_cnt saturates at NUM_SPARES+1 and the table is unchanged.
- Multiple bit errors in one word count as one address. Repeated failures of the same address in later elements count once.
- DONE: outputs held, mem_en=0, until start or rst.

Optional Feature:
- Macro: MBIST_CKBD_EN.
- Defined: BG bit i = i[0] ^ addr[0] (per-address checkerboard). Expected values and written data are derived per address. Cycle count is unchanged.
- Undefined: BG is all zeros.

Decomposition:
- mbist_pkg:
  - state enum;
  - element encoding;
  - march table constants: per elem, read-expect polarity, write polarity, direction, has_write;
  - fail_cnt width function.
- Sub-module mbist_fail_log:
  - NUM_SPARES-entry CAM-style table;
  - inputs: clear, log_en, log_addr;
  - outputs: spare_addr, spare_vld, fail_cnt, fail_addr.
- The engine instantiates one mbist_fail_log.

Test Plan (DATA_W=8, ADDR_W=5, DEPTH=32, NUM_SPARES=2; behavioural SRAM with fault injection):
- Fault-free: start pulse -> done at edge 353, fail=0, fail_cnt=0, spare_vld=00, repair_ok=1; mem_addr sequence descending during M3/M4.
- Bit 3 of address 5 stuck-at-1 -> fail=1, fail_addr=5, fail_cnt=1, spare_vld=01, entry0=5, repair_ok=1. Address 5 is detected in M1, M3 and M5 but counted once.
- Stuck-at-0 on all bits of addresses 2, 9 and 30 -> fail_cnt=3 (saturated), entry0=2, entry1=9, spare_vld=11, repair_ok=0, fail_addr=2.
- rst asserted for one cycle at cycle 100 of a run -> next cycle busy=0, mem_en=0, all results 0. A following start completes in 353 edges with clean results.
- start pulsed while busy at cycle 50 -> ignored (done still at edge 353). start in DONE -> done=0 the next cycle and the test reruns.
- With MBIST_CKBD_EN: fault-free -> writes 0xAA at even and 0x55 at odd addresses in M0, fail=0. A stuck-at-0 on bit 1 of address 4 is detected -> fail_addr=4.

Source files
------------

// File: rtl/mbist_pkg.sv
// mbist_pkg: shared definitions for the March C- MBIST engine.
//   - state_e   : engine FSM states
//   - elem_e    : March element index M0..M5
//   - RD_POL/WR_POL/DIR_DN/HAS_WR : per-element march table, one bit per
//     element (bit n = element Mn). Polarity 1 means the "1" data, which is
//     the complement of the background.
//   - fcnt_w()  : width of the saturating fail counter (0..NUM_SPARES+1)
package mbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_READ,
        ST_CHECK,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        EL_M0,  // up   w0
        EL_M1,  // up   r0,w1
        EL_M2,  // up   r1,w0
        EL_M3,  // down r0,w1
        EL_M4,  // down r1,w0
        EL_M5   // up   r0
    } elem_e;

    // Tables are 8 bits wide so any 3-bit element index stays in range.
    localparam logic [7:0] RD_POL = 8'b0001_0100;  // M2, M4 expect "1"
    localparam logic [7:0] WR_POL = 8'b0000_1010;  // M1, M3 write "1"
    localparam logic [7:0] DIR_DN = 8'b0001_1000;  // M3, M4 sweep downward
    localparam logic [7:0] HAS_WR = 8'b0001_1111;  // M0..M4 write; M5 read-only

    function automatic int fcnt_w(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/mbist_fail_log.sv
// mbist_fail_log: CAM-style repair table for the MBIST engine.
// Logs up to NUM_SPARES distinct failing addresses in detection order
// (lowest free entry first) and counts distinct failing addresses,
// saturating at NUM_SPARES+1 once the table overflows.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear          synchronous clear of all results (new test start)
//   log_en         a mismatch was seen this cycle at log_addr
//   log_addr       failing address
//   spare_addr     packed table, entry k at [k*ADDR_W +: ADDR_W]
//   spare_vld      entry valid bits
//   fail_cnt       distinct failing addresses (saturating)
//   fail_addr      first failing address of the run
module mbist_fail_log #(
    parameter int ADDR_W     = 5,
    parameter int NUM_SPARES = 2,
    parameter int CNT_W      = $clog2(NUM_SPARES + 2)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         log_en,
    input  logic [ADDR_W-1:0]            log_addr,
    output logic [NUM_SPARES*ADDR_W-1:0] spare_addr,
    output logic [NUM_SPARES-1:0]        spare_vld,
    output logic [CNT_W-1:0]             fail_cnt,
    output logic [ADDR_W-1:0]            fail_addr
);

    logic [NUM_SPARES-1:0][ADDR_W-1:0] entry;
    logic                              hit;
    logic                              has_free;
    logic [NUM_SPARES-1:0]             free_sel;  // one-hot lowest free entry

    always_comb begin
        hit      = 1'b0;
        has_free = 1'b0;
        free_sel = '0;
        for (int k = 0; k < NUM_SPARES; k++) begin
            if (spare_vld[k] && entry[k] == log_addr) hit = 1'b1;
            if (!spare_vld[k] && !has_free) begin
                free_sel[k] = 1'b1;
                has_free    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            entry     <= '0;
            spare_vld <= '0;
            fail_cnt  <= '0;
            fail_addr <= '0;
        end else if (log_en) begin
            // Any mismatch bumps fail_cnt from zero, so zero marks the first one.
            if (fail_cnt == '0) fail_addr <= log_addr;
            if (!hit) begin
                if (has_free) begin
                    for (int k = 0; k < NUM_SPARES; k++)
                        if (free_sel[k]) entry[k] <= log_addr;
                    spare_vld <= spare_vld | free_sel;
                    fail_cnt  <= fail_cnt + 1'b1;
                end else begin
                    fail_cnt <= CNT_W'(NUM_SPARES + 1);
                end
            end
        end
    end

    assign spare_addr = entry;

endmodule

// File: rtl/mbist_march_engine.sv
// mbist_march_engine: March C- MBIST engine for a single-port SRAM with
// repair-table capture.
// Optional feature: define MBIST_CKBD_EN for a per-address checkerboard
// background (bit i = i[0] ^ addr[0]); otherwise the background is all zeros.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request, honoured in IDLE or DONE only
//   busy, done, fail    status; done held until restart or reset
//   repair_ok           done and all failing addresses fit in the spares
//   fail_cnt, fail_addr distinct failing addresses, first failing address
//   spare_addr/vld      repair table
//   mem_*               SRAM port; mem_rdata valid the cycle after a read
module mbist_march_engine
    import mbist_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 32,
    parameter int NUM_SPARES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              fail,
    output logic                              repair_ok,
    output logic [$clog2(NUM_SPARES+2)-1:0]   fail_cnt,
    output logic [ADDR_W-1:0]                 fail_addr,
    output logic [NUM_SPARES*ADDR_W-1:0]      spare_addr,
    output logic [NUM_SPARES-1:0]             spare_vld,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic [DATA_W-1:0]                 mem_rdata
);

    localparam int                CNT_W = fcnt_w(NUM_SPARES);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
`ifdef MBIST_CKBD_EN
    localparam logic CKBD = 1'b1;
`else
    localparam logic CKBD = 1'b0;
`endif

    // Data for polarity pol at an address with LSB a0: background, or its
    // complement for the "1" polarity.
    function automatic logic [DATA_W-1:0] pattern(input logic pol, input logic a0);
        logic [DATA_W-1:0] p;
        for (int i = 0; i < DATA_W; i++) p[i] = pol ^ (CKBD & (i[0] ^ a0));
        return p;
    endfunction

    state_e            state, nxt_state;
    elem_e             elem, nxt_elem;
    logic [ADDR_W-1:0] addr, nxt_addr;
    logic              accept, sweep_end, mismatch, log_en;

    assign accept    = start && (state == ST_IDLE || state == ST_DONE);
    assign sweep_end = DIR_DN[elem] ? (addr == '0) : (addr == LAST);
    assign mismatch  = mem_rdata != pattern(RD_POL[elem], addr[0]);
    assign log_en    = (state == ST_CHECK) && mismatch;

    always_comb begin
        nxt_state = state;
        nxt_elem  = elem;
        nxt_addr  = addr;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    nxt_state = ST_INIT;
                    nxt_elem  = EL_M0;
                    nxt_addr  = '0;
                end
            end
            ST_INIT: begin
                if (addr == LAST) begin
                    nxt_state = ST_READ;
                    nxt_elem  = EL_M1;
                    nxt_addr  = '0;
                end else begin
                    nxt_addr = addr + 1'b1;
                end
            end
            ST_READ: nxt_state = ST_CHECK;
            ST_CHECK: begin
                nxt_state = ST_READ;
                if (!sweep_end) begin
                    nxt_addr = DIR_DN[elem] ? addr - 1'b1 : addr + 1'b1;
                end else if (elem == EL_M5) begin
                    nxt_state = ST_DONE;
                end else begin
                    nxt_elem = elem_e'(elem + 3'd1);
                    nxt_addr = DIR_DN[nxt_elem] ? LAST : '0;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Memory port is registered: the values loaded here are what the port
    // shows while the FSM sits in nxt_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            elem      <= EL_M0;
            addr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= nxt_state;
            elem  <= nxt_elem;
            addr  <= nxt_addr;
            if (accept) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (state == ST_DONE) begin
                // One cycle after the last CHECK so the final log update is
                // already visible when done rises.
                busy <= 1'b0;
                done <= 1'b1;
            end
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= nxt_addr;
            mem_wdata <= '0;
            case (nxt_state)
                ST_INIT: begin
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_wdata <= pattern(1'b0, nxt_addr[0]);
                end
                ST_READ: mem_en <= 1'b1;
                ST_CHECK: begin
                    if (HAS_WR[nxt_elem]) begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= pattern(WR_POL[nxt_elem], nxt_addr[0]);
                    end
                end
                default: ;
            endcase
        end
    end

    mbist_fail_log #(
        .ADDR_W     (ADDR_W),
        .NUM_SPARES (NUM_SPARES),
        .CNT_W      (CNT_W)
    ) u_fail_log (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .log_en     (log_en),
        .log_addr   (addr),
        .spare_addr (spare_addr),
        .spare_vld  (spare_vld),
        .fail_cnt   (fail_cnt),
        .fail_addr  (fail_addr)
    );

    assign fail      = fail_cnt != '0;
    assign repair_ok = done && (fail_cnt <= CNT_W'(NUM_SPARES));

endmodule
